// File: rtl/hilo_mdu_pkg.sv
// hilo_mdu_pkg: shared definitions for the HI/LO multiply/divide unit.
//   mdu_op_e    - operation codes presented by EX on the op field
//   mdu_state_e - MDU sequencer states
//   HI_LO_WD    - width of the combined HI/LO write bus
//   is_mul/is_div/is_signed_op - op-class decode helpers
package hilo_mdu_pkg;

    typedef enum logic [2:0] {
        MDU_OP_NOP   = 3'd0,
        MDU_OP_MULT  = 3'd1,
        MDU_OP_MULTU = 3'd2,
        MDU_OP_DIV   = 3'd3,
        MDU_OP_DIVU  = 3'd4,
        MDU_OP_MTHI  = 3'd5,
        MDU_OP_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    localparam int unsigned HI_LO_WD = 64;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_mdu_if.sv
// hilo_mdu_if: EX-stage <-> MDU bus.
//   master (EX side): drives flush, start, op, src_a, src_b;
//                     receives stallreq, busy, hi_we, lo_we, hi_o, lo_o.
//   slave  (MDU)    : the reverse.
interface hilo_mdu_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             flush;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             stallreq;
    logic             busy;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output flush, start, op, src_a, src_b,
        input  stallreq, busy, hi_we, lo_we, hi_o, lo_o
    );

    modport slave (
        input  flush, start, op, src_a, src_b,
        output stallreq, busy, hi_we, lo_we, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_mdu_div_step.sv
// mdu_div_step: one combinational restoring-divide iteration on magnitudes.
//   i_rem/i_quo : partial remainder and dividend/quotient shift register
//   i_div       : divisor magnitude
//   o_rem/o_quo : values after shifting in one dividend bit and trial subtract
module mdu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_div});
    // When the subtract succeeds the true difference is below the divisor,
    // so it always fits in WIDTH bits.
    assign w_diff  = w_shift[WIDTH-1:0] - i_div;
    assign o_rem   = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign o_quo   = {i_quo[WIDTH-2:0], w_ge};
endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: multi-cycle multiply/divide unit, writer side of HI/LO.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : flush/start/op/src_a/src_b in; stallreq/busy,
//                 hi_we/lo_we strobes and hi_o/lo_o write data out
// MULT/MULTU/DIV/DIVU iterate WIDTH radix-2 steps (BUSY) then emit one
// write pulse (DONE); MTHI/MTLO go straight to DONE.
// Optional: define MDU_FAST_MULT_EN for a single-cycle MULT/MULTU path.
module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic         clk,
    input logic         resetn,
    hilo_mdu_if.slave   bus
);
    mdu_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_divz;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_hi_we;
    logic               r_lo_we;

    // Operand decode in the start cycle
    logic             w_sa, w_sb, w_neg_in, w_op_div, w_iter_op;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;

    assign w_sa     = is_signed_op(bus.op) & bus.src_a[WIDTH-1];
    assign w_sb     = is_signed_op(bus.op) & bus.src_b[WIDTH-1];
    assign w_neg_in = w_sa ^ w_sb;
    assign w_mag_a  = w_sa ? -bus.src_a : bus.src_a;
    assign w_mag_b  = w_sb ? -bus.src_b : bus.src_b;
    assign w_op_div = is_div(bus.op);
`ifdef MDU_FAST_MULT_EN
    assign w_iter_op = w_op_div;

    logic [2*WIDTH-1:0] w_fast_mag, w_fast_prod;
    assign w_fast_mag  = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
    assign w_fast_prod = w_neg_in ? -w_fast_mag : w_fast_mag;
`else
    assign w_iter_op = w_op_div | is_mul(bus.op);
`endif

    // Multiply step: acc = {partial product, remaining multiplier bits}
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // Divide step: acc = {remainder, dividend/quotient}
    logic [WIDTH-1:0] w_div_rem, w_div_quo;

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem (r_acc[2*WIDTH-1:WIDTH]),
        .i_quo (r_acc[WIDTH-1:0]),
        .i_div (r_opnd),
        .o_rem (w_div_rem),
        .o_quo (w_div_quo)
    );

    logic [2*WIDTH-1:0] w_acc_next;
    assign w_acc_next = r_is_div ? {w_div_rem, w_div_quo} : w_mul_next;

    // Sign fix-up is computed on the final step so that DONE only has to
    // present registered data.
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix, w_rem_fix, w_res_hi, w_res_lo;

    assign w_prod_fix = r_neg_q ? -w_acc_next : w_acc_next;
    assign w_quo_fix  = r_divz  ? '1
                      : (r_neg_q ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0]);
    assign w_rem_fix  = r_neg_r ? -w_acc_next[2*WIDTH-1:WIDTH]
                                : w_acc_next[2*WIDTH-1:WIDTH];
    assign w_res_hi   = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_res_lo   = r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_divz   <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_hi_we  <= 1'b0;
            r_lo_we  <= 1'b0;
        end else if (bus.flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_hi_we <= 1'b0;
            r_lo_we <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (w_iter_op) begin
                            r_is_div <= w_op_div;
                            r_neg_q  <= w_neg_in;
                            r_neg_r  <= w_sa;
                            r_divz   <= w_op_div & (bus.src_b == '0);
                            r_opnd   <= w_op_div ? w_mag_b : w_mag_a;
                            r_acc    <= {{WIDTH{1'b0}}, (w_op_div ? w_mag_a : w_mag_b)};
                            r_cnt    <= '0;
                            r_state  <= ST_BUSY;
                        end
`ifdef MDU_FAST_MULT_EN
                        else if (is_mul(bus.op)) begin
                            r_hi    <= w_fast_prod[2*WIDTH-1:WIDTH];
                            r_lo    <= w_fast_prod[WIDTH-1:0];
                            r_hi_we <= 1'b1;
                            r_lo_we <= 1'b1;
                            r_state <= ST_DONE;
                        end
`endif
                        else if (bus.op == MDU_OP_MTHI) begin
                            r_hi    <= bus.src_a;
                            r_lo    <= '0;
                            r_hi_we <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (bus.op == MDU_OP_MTLO) begin
                            r_hi    <= '0;
                            r_lo    <= bus.src_a;
                            r_lo_we <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_hi_we <= 1'b1;
                        r_lo_we <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_hi    <= '0;
                    r_lo    <= '0;
                    r_hi_we <= 1'b0;
                    r_lo_we <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are suppressed by a same-cycle flush or reset.
    assign bus.hi_we    = r_hi_we & ~bus.flush & resetn;
    assign bus.lo_we    = r_lo_we & ~bus.flush & resetn;
    assign bus.hi_o     = r_hi;
    assign bus.lo_o     = r_lo;
    assign bus.busy     = (r_state == ST_BUSY);
    assign bus.stallreq = (r_state == ST_BUSY)
                        | ((r_state == ST_IDLE) & bus.start & ~bus.flush
                           & (is_mul(bus.op) | w_op_div));
endmodule
